// File: rtl/router_pkt_tx.sv
// rtl/router_pkt_tx.sv - stages a full packet, then drives header/payload/parity into the 1x3 router
module router_pkt_tx #(
   parameter int GAP_CYCLES = 2
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_addr,
   input  logic [5:0] cmd_len,
   input  logic       cmd_inj_err,
   output logic       cmd_err,
   input  logic       pl_valid,
   output logic       pl_ready,
   input  logic [7:0] pl_data,
   input  logic       busy,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   output logic       tx_done
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_HDR, S_PAYLOAD, S_PARITY, S_GAP
   } state_t;

   localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

   state_t     state, state_n;
   logic [7:0] buffer [64];
   logic [5:0] len_q, len_n;
   logic       inj_q, inj_n;
   logic [7:0] header_q, header_n;
   logic [7:0] parity_q, parity_n;
   logic [5:0] count_q, count_n;
   logic [5:0] index_q, index_n;
   logic [3:0] gap_q, gap_n;
   logic       pkt_valid_n, cmd_err_n, tx_done_n;
   logic [7:0] data_out_n;
   logic       buf_we;

   assign cmd_ready = resetn && (state == S_IDLE);
   assign pl_ready  = resetn && (state == S_LOAD);

   always_comb begin
      state_n   = state;
      len_n     = len_q;
      inj_n     = inj_q;
      header_n  = header_q;
      parity_n  = parity_q;
      count_n   = count_q;
      index_n   = index_q;
      gap_n     = gap_q;
      cmd_err_n = 1'b0;
      tx_done_n = 1'b0;
      buf_we    = 1'b0;
      case (state)
         S_IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == 6'd0 || cmd_addr == 2'd3) begin
                  cmd_err_n = 1'b1;
               end else begin
                  len_n    = cmd_len;
                  inj_n    = cmd_inj_err;
                  header_n = {cmd_len, cmd_addr};
                  parity_n = {cmd_len, cmd_addr};
                  count_n  = 6'd0;
                  state_n  = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            if (pl_valid) begin
               buf_we   = 1'b1;
               parity_n = parity_q ^ pl_data;
               count_n  = count_q + 6'd1;
               if (count_q == len_q - 6'd1) state_n = S_HDR;
            end
         end
         S_HDR: begin
            if (!busy) begin
               index_n = 6'd0;
               state_n = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            if (!busy) begin
               index_n = index_q + 6'd1;
               if (index_q == len_q - 6'd1) state_n = S_PARITY;
            end
         end
         S_PARITY: begin
            if (!busy) begin
               tx_done_n = 1'b1;
               gap_n     = 4'd0;
               state_n   = S_GAP;
            end
         end
         S_GAP: begin
            if (gap_q == GAP_LAST) state_n = S_IDLE;
            else                   gap_n   = gap_q + 4'd1;
         end
         default: state_n = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from where the FSM is going next.
      pkt_valid_n = (state_n == S_HDR) || (state_n == S_PAYLOAD);
      case (state_n)
         S_HDR:     data_out_n = header_n;
         S_PAYLOAD: data_out_n = buffer[index_n];
         S_PARITY:  data_out_n = parity_n ^ {8{inj_n}};
         default:   data_out_n = 8'h00;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state     <= S_IDLE;
         len_q     <= 6'd0;
         inj_q     <= 1'b0;
         header_q  <= 8'h00;
         parity_q  <= 8'h00;
         count_q   <= 6'd0;
         index_q   <= 6'd0;
         gap_q     <= 4'd0;
         pkt_valid <= 1'b0;
         data_out  <= 8'h00;
         cmd_err   <= 1'b0;
         tx_done   <= 1'b0;
      end else begin
         state     <= state_n;
         len_q     <= len_n;
         inj_q     <= inj_n;
         header_q  <= header_n;
         parity_q  <= parity_n;
         count_q   <= count_n;
         index_q   <= index_n;
         gap_q     <= gap_n;
         pkt_valid <= pkt_valid_n;
         data_out  <= data_out_n;
         cmd_err   <= cmd_err_n;
         tx_done   <= tx_done_n;
      end
   end

   // Payload store needs no reset: only bytes written for the current packet are ever read.
   always_ff @(posedge clock) begin
      if (resetn && buf_we) buffer[count_q] <= pl_data;
   end

endmodule

// File: tb/tb_router_pkt_tx.sv
// tb/tb_router_pkt_tx.sv - randomized self-checking bench for router_pkt_tx
module tb_router_pkt_tx;

   logic       clock = 1'b0;
   logic       resetn = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_addr = 2'd0;
   logic [5:0] cmd_len = 6'd0;
   logic       cmd_inj_err = 1'b0;
   logic       cmd_err;
   logic       pl_valid = 1'b0;
   logic       pl_ready;
   logic [7:0] pl_data = 8'h00;
   logic       busy = 1'b0;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_done;

   int n_cmp = 0;
   int n_fail = 0;

   logic [8:0] mon_q[$];
   int         tx_cnt = 0;
   int         err_cnt = 0;
   int         pv_cnt = 0;
   int         hold22 = 0;
   bit         par_pend = 1'b0;
   logic [7:0] src[$];

   router_pkt_tx dut (
      .clock(clock), .resetn(resetn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_inj_err(cmd_inj_err), .cmd_err(cmd_err),
      .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
      .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out), .tx_done(tx_done)
   );

   always #5 clock = ~clock;

   // Router-side observer: logs every byte the router would take, tagged with pkt_valid.
   always @(negedge clock) begin
      if (!resetn) begin
         par_pend = 1'b0;
      end else begin
         if (pkt_valid) begin
            pv_cnt++;
            if (data_out == 8'h22) hold22++;
            if (!busy) mon_q.push_back({1'b1, data_out});
            par_pend = 1'b1;
         end else if (par_pend && !busy) begin
            mon_q.push_back({1'b0, data_out});
            par_pend = 1'b0;
         end
         if (tx_done) tx_cnt++;
         if (cmd_err) err_cnt++;
      end
   end

   // mode 0: random busy at busy_pct percent; mode 1: stall the 0x22 byte for 3 cycles.
   task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj,
                          input int busy_pct, input int mode, output int base);
      logic [8:0] exp_q[$];
      logic [7:0] par;
      int guard, sent, cyc, hdr_cyc, tx_cyc, stalls, txb, eb, hb;
      bit done, hdr_chk;
      par = {l, a};
      exp_q.push_back({1'b1, l, a});
      for (int i = 0; i < int'(l); i++) begin
         exp_q.push_back({1'b1, src[i]});
         par = par ^ src[i];
      end
      exp_q.push_back({1'b0, inj ? ~par : par});

      guard = 0;
      while (cmd_ready !== 1'b1 && guard < 200) begin
         @(posedge clock); #1;
         guard++;
      end
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready);
      end
      base = mon_q.size(); txb = tx_cnt; eb = err_cnt; hb = hold22;
      cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_inj_err = inj;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      sent = 0; done = 1'b0; hdr_chk = 1'b0; cyc = 0; hdr_cyc = 0; tx_cyc = 0; stalls = 0;
      while (!done && cyc < 3000) begin
         if (hdr_chk) begin
            hdr_chk = 1'b0;
            hdr_cyc = cyc;
            n_cmp++;
            if (pkt_valid !== 1'b1 || data_out !== {l, a} || pl_ready !== 1'b0) begin
               n_fail++;
               $display("FAIL header_after_load: pv=%b data=%h pl_ready=%b want pv=1 data=%h pl_ready=0",
                        pkt_valid, data_out, pl_ready, {l, a});
            end
         end
         if (tx_done === 1'b1) begin
            done = 1'b1;
            tx_cyc = cyc;
         end else begin
            if (mode == 1) begin
               busy = (pkt_valid === 1'b1 && data_out === 8'h22 && stalls < 3);
               if (busy) stalls++;
            end else begin
               busy = (int'($urandom_range(99)) < busy_pct);
            end
            if (pl_ready === 1'b1 && sent < int'(l) && $urandom_range(3) != 0) begin
               pl_valid = 1'b1;
               pl_data = src[sent];
               sent++;
               if (sent == int'(l)) hdr_chk = 1'b1;
            end else begin
               pl_valid = (pl_ready === 1'b1) ? 1'b0 : 1'($urandom_range(1));
               pl_data = 8'($urandom);
            end
            cmd_valid = 1'($urandom_range(1));
            cmd_addr = 2'd3;
            cmd_len = 6'($urandom);
            @(posedge clock); #1;
            cyc++;
         end
      end
      cmd_valid = 1'b0; pl_valid = 1'b0; busy = 1'b0;
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL tx_done_timeout: no tx_done within %0d cycles", cyc);
      end
      n_cmp++;
      if (pkt_valid !== 1'b0 || data_out !== 8'h00 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_first: pv=%b data=%h cmd_ready=%b want 0/00/0", pkt_valid, data_out, cmd_ready);
      end
      @(posedge clock); #1;
      n_cmp++;
      if (cmd_ready !== 1'b0 || tx_done !== 1'b0 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL gap_second: cmd_ready=%b tx_done=%b data=%h want 0/0/00", cmd_ready, tx_done, data_out);
      end
      @(posedge clock); #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL cmd_ready_after_gap: got %b want 1", cmd_ready);
      end
      n_cmp++;
      if (mon_q.size() - base != int'(l) + 2) begin
         n_fail++;
         $display("FAIL stream_len: got %0d bytes want %0d", mon_q.size() - base, int'(l) + 2);
      end else begin
         for (int i = 0; i < int'(l) + 2; i++) begin
            n_cmp++;
            if (mon_q[base + i] !== exp_q[i]) begin
               n_fail++;
               $display("FAIL stream_byte[%0d]: got pv/data %h want %h", i, mon_q[base + i], exp_q[i]);
            end
         end
      end
      n_cmp++;
      if (tx_cnt - txb != 1 || err_cnt - eb != 0) begin
         n_fail++;
         $display("FAIL pulse_count: tx_done %0d cmd_err %0d want 1 and 0", tx_cnt - txb, err_cnt - eb);
      end
      if (mode == 0 && busy_pct == 0) begin
         n_cmp++;
         if (tx_cyc - hdr_cyc != int'(l) + 2) begin
            n_fail++;
            $display("FAIL packet_cycles: got %0d want %0d", tx_cyc - hdr_cyc, int'(l) + 2);
         end
      end
      if (mode == 1) begin
         n_cmp++;
         if (hold22 - hb != 4) begin
            n_fail++;
            $display("FAIL stall_hold: 0x22 shown %0d cycles want 4", hold22 - hb);
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      n_cmp++;
      if ({cmd_ready, cmd_err, pl_ready, pkt_valid, tx_done} !== 5'b0 || data_out !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy/err/plr/pv/done=%b data=%h want 00000/00",
                  {cmd_ready, cmd_err, pl_ready, pkt_valid, tx_done}, data_out);
      end
      resetn = 1'b1;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
      end
   endtask

   task automatic test_basic();
      int base;
      src = '{8'h11, 8'h22, 8'h33};
      run_pkt(2'd1, 6'd3, 1'b0, 0, 0, base);
      n_cmp++;
      if (mon_q[base] !== 9'h10D || mon_q[base + 4] !== 9'h00D) begin
         n_fail++;
         $display("FAIL basic_hdr_parity: got %h %h want 10d 00d", mon_q[base], mon_q[base + 4]);
      end
   endtask

   task automatic test_stall();
      int base;
      src = '{8'h11, 8'h22, 8'h33};
      run_pkt(2'd1, 6'd3, 1'b0, 0, 1, base);
   endtask

   task automatic test_reject();
      int eb, pb;
      logic [1:0] a;
      logic [5:0] l;
      for (int i = 0; i < 2; i++) begin
         a = (i == 0) ? 2'd1 : 2'd3;
         l = (i == 0) ? 6'd0 : 6'd5;
         eb = err_cnt; pb = pv_cnt;
         cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; cmd_inj_err = 1'b0;
         @(posedge clock); #1;
         cmd_valid = 1'b0;
         n_cmp++;
         if (cmd_err !== 1'b1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_pulse[%0d]: cmd_err=%b cmd_ready=%b want 1/1", i, cmd_err, cmd_ready);
         end
         @(posedge clock); #1;
         n_cmp++;
         if (cmd_err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_end[%0d]: cmd_err=%b cmd_ready=%b want 0/1", i, cmd_err, cmd_ready);
         end
         repeat (3) @(posedge clock);
         #1;
         n_cmp++;
         if (pv_cnt != pb || err_cnt - eb != 1 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reject_quiet[%0d]: pv cycles %0d errs %0d rdy %b want 0/1/1",
                     i, pv_cnt - pb, err_cnt - eb, cmd_ready);
         end
      end
   endtask

   task automatic test_inject();
      int base;
      src = '{8'h11, 8'h22, 8'h33};
      run_pkt(2'd1, 6'd3, 1'b1, 20, 0, base);
      n_cmp++;
      if (mon_q[base + 4] !== 9'h0F2) begin
         n_fail++;
         $display("FAIL inject_parity: got %h want 0f2", mon_q[base + 4]);
      end
   endtask

   task automatic test_max_len();
      int base;
      src.delete();
      for (int i = 0; i < 63; i++) src.push_back(8'(i));
      run_pkt(2'd2, 6'd63, 1'b0, 30, 0, base);
      n_cmp++;
      if (mon_q[base] !== 9'h1FE) begin
         n_fail++;
         $display("FAIL max_header: got %h want 1fe", mon_q[base]);
      end
   endtask

   task automatic test_reset_mid();
      int base, guard;
      src = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
      cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd4; cmd_inj_err = 1'b0;
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      guard = 0;
      base = 0;
      while (!(pkt_valid === 1'b1 && data_out === 8'hB2) && guard < 100) begin
         busy = 1'b0;
         if (pl_ready === 1'b1 && base < 4) begin
            pl_valid = 1'b1; pl_data = src[base]; base++;
         end else begin
            pl_valid = 1'b0;
         end
         @(posedge clock); #1;
         guard++;
      end
      pl_valid = 1'b0;
      n_cmp++;
      if (guard >= 100) begin
         n_fail++;
         $display("FAIL reset_mid_reach: second payload byte never presented");
      end
      resetn = 1'b0;
      @(posedge clock); #1;
      n_cmp++;
      if (pkt_valid !== 1'b0 || data_out !== 8'h00 || cmd_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_clear: pv=%b data=%h rdy=%b want 0/00/0", pkt_valid, data_out, cmd_ready);
      end
      resetn = 1'b1;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_ready: got %b want 1", cmd_ready);
      end
      src = '{8'h5A, 8'h00, 8'hFF};
      run_pkt(2'd2, 6'd3, 1'b0, 0, 0, base);
   endtask

   task automatic test_random();
      int base;
      logic [5:0] l;
      for (int k = 0; k < 10; k++) begin
         l = (k % 3 == 0) ? 6'd1 : 6'($urandom_range(63, 1));
         src.delete();
         for (int i = 0; i < int'(l); i++) src.push_back(8'($urandom));
         run_pkt(2'($urandom_range(2)), l, 1'($urandom_range(1)),
                 (k % 2 == 0) ? 0 : int'($urandom_range(60)), 0, base);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_reject();
      test_inject();
      test_max_len();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
